// File: rtl/debug_pkg.sv
// debug_pkg: shared encodings for the debug-halt controller
package debug_pkg;
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [5:0] REG_CTRL       = 6'h00;
  localparam logic [5:0] REG_STATUS     = 6'h01;
  localparam logic [5:0] REG_STEP_LEN   = 6'h02;
  localparam logic [5:0] REG_HALT_COUNT = 6'h03;
  localparam logic [5:0] REG_ID         = 6'h04;
  localparam logic [5:0] REG_SCRATCH0   = 6'h05;
  localparam logic [5:0] REG_SCRATCH1   = 6'h06;
  localparam int CTRL_HALT = 0;
  localparam int CTRL_STEP = 1;
  localparam int CTRL_RUN  = 2;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: registers a synchronous input once and flags its rising edge
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise
);
  logic r_cur, r_prev;
  // current/previous samples; reset discards any pending edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_cur  <= i_d;
      r_prev <= r_cur;
    end
  assign o_rise = r_cur & ~r_prev;
endmodule

// File: rtl/cpu_debug.sv
// cpu_debug: JTAG debug-halt controller with debug register bank
module cpu_debug
  import debug_pkg::*;
#(
  parameter bit          HALT_ON_RESET = 1'b0,
  parameter logic [15:0] STEP_CYCLES   = 16'd1,
  parameter logic [31:0] DEBUG_ID      = 32'h0DB6_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rd_wr,
  input  logic [31:0] address,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  input  logic        step,
  input  logic        run,
  output logic        halt
);
  localparam logic [1:0] RESET_STATE = HALT_ON_RESET ? ST_HALT : ST_RUN;
  logic        w_en_rise, w_step_rise, w_run_rise;
  logic        r_wr;
  logic [31:2] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_state, w_next;
  logic [15:0] r_cnt, w_cnt_next, r_step_len;
  logic [31:0] r_halt_cnt, r_scratch0, r_scratch1, w_rdata;
  logic [5:0]  w_sel;
  logic        w_mapped, w_wr, w_rd, w_ctrl_wr, w_halt_req, w_step_req, w_run_req;

  edge_detect u_en   (.clk(clk), .reset(reset), .i_d(enable), .o_rise(w_en_rise));
  edge_detect u_step (.clk(clk), .reset(reset), .i_d(step),   .o_rise(w_step_rise));
  edge_detect u_run  (.clk(clk), .reset(reset), .i_d(run),    .o_rise(w_run_rise));

  // access qualifiers registered in step with the enable sample
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_wr    <= rd_wr;
      r_addr  <= address[31:2];
      r_wdata <= data_out;
    end

  assign w_sel      = r_addr[7:2];
  assign w_mapped   = r_addr[31:8] == 24'd0;
  assign w_wr       = w_en_rise & r_wr & w_mapped;
  assign w_rd       = w_en_rise & ~r_wr;
  assign w_ctrl_wr  = w_wr & (w_sel == REG_CTRL);
  assign w_halt_req = w_ctrl_wr & r_wdata[CTRL_HALT];
  assign w_step_req = w_step_rise | (w_ctrl_wr & r_wdata[CTRL_STEP]);
  assign w_run_req  = w_run_rise | (w_ctrl_wr & r_wdata[CTRL_RUN]);

  // next state with halt > run > step priority; a zero step length still runs one clock
  always_comb begin
    w_next     = ST_HALT;
    w_cnt_next = r_cnt;
    if (r_state == ST_RUN)
      w_next = (w_halt_req | w_step_req) ? ST_HALT : ST_RUN;
    else if (r_state == ST_HALT) begin
      w_next = w_halt_req ? ST_HALT : w_run_req ? ST_RUN : w_step_req ? ST_STEP : ST_HALT;
      if (!w_halt_req && !w_run_req && w_step_req)
        w_cnt_next = (r_step_len == 16'd0) ? 16'd1 : r_step_len;
    end else if (r_state == ST_STEP) begin
      w_next = w_halt_req ? ST_HALT : w_run_req ? ST_RUN : (r_cnt <= 16'd1) ? ST_HALT : ST_STEP;
      w_cnt_next = r_cnt - 16'd1;
    end
  end

  // read mux; unmapped addresses and write-only CTRL read as zero
  always_comb begin
    w_rdata = '0;
    if (w_mapped)
      case (w_sel)
        REG_STATUS:     w_rdata = {29'd0, halt, r_state};
        REG_STEP_LEN:   w_rdata = {16'd0, r_step_len};
        REG_HALT_COUNT: w_rdata = r_halt_cnt;
        REG_ID:         w_rdata = DEBUG_ID;
        REG_SCRATCH0:   w_rdata = r_scratch0;
        REG_SCRATCH1:   w_rdata = r_scratch1;
        default:        w_rdata = '0;
      endcase
  end

  // FSM state, step counter and registered halt level
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= RESET_STATE;
      r_cnt   <= '0;
      halt    <= HALT_ON_RESET;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      halt    <= w_next == ST_HALT;
    end

  // register bank; a HALT_COUNT write clears and beats that cycle's increment
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_step_len <= STEP_CYCLES;
      r_halt_cnt <= '0;
      r_scratch0 <= '0;
      r_scratch1 <= '0;
      data_in    <= '0;
    end else begin
      if (w_wr && w_sel == REG_STEP_LEN) r_step_len <= r_wdata[15:0];
      if (w_wr && w_sel == REG_HALT_COUNT) r_halt_cnt <= '0;
      else if (halt && r_halt_cnt != '1) r_halt_cnt <= r_halt_cnt + 32'd1;
      if (w_wr && w_sel == REG_SCRATCH0) r_scratch0 <= r_wdata;
      if (w_wr && w_sel == REG_SCRATCH1) r_scratch1 <= r_wdata;
      if (w_rd) data_in <= w_rdata;
    end
endmodule

// File: tb/tb_cpu_debug.sv
// tb_cpu_debug: randomized self-checking bench against a register-level model
module tb_cpu_debug;
  logic clk = 0, reset = 0, enable = 0, rd_wr = 0, step = 0, run = 0;
  logic [31:0] address = 0, data_out = 0;
  logic [31:0] data_in;
  logic halt;
  int total = 0, bad = 0;
  int m_state = 0;
  logic [15:0] m_len = 16'd1;
  logic [31:0] m_scr [2] = '{32'd0, 32'd0};
  localparam logic [31:0] ID = 32'h0DB6_0001;

  always #5 clk = ~clk;

  cpu_debug dut (
    .clk(clk), .reset(reset), .enable(enable), .rd_wr(rd_wr), .address(address),
    .data_out(data_out), .data_in(data_in), .step(step), .run(run), .halt(halt)
  );

  function automatic logic [31:0] m_status();
    return {29'd0, m_state == 1, 2'(m_state)};
  endfunction

  task automatic bus(input logic wr, input logic [31:0] a, input logic [31:0] d, output logic [31:0] q);
    rd_wr = wr; address = a; data_out = d; enable = 1;
    @(negedge clk); @(negedge clk);
    enable = 0; q = data_in;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(1'b1, a, d, q);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    bus(1'b0, a, 32'd0, q);
  endtask

  task automatic pulse(input logic s, input logic r);
    step = s; run = r;
    @(negedge clk);
    step = 0; run = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] q;
    repeat (3) @(negedge clk);
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b exp=0", halt); end
    total++; if (data_in !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_in); end
    reset = 1;
    @(negedge clk);
    rd(32'h10, q);
    total++; if (q !== ID) begin bad++; $display("FAIL id got=%h exp=%h", q, ID); end
    rd(32'h04, q);
    total++; if (q !== m_status()) begin bad++; $display("FAIL status_reset got=%h exp=%h", q, m_status()); end
    rd(32'h20, q);
    total++; if (q !== 32'd0) begin bad++; $display("FAIL unmapped_rd got=%h exp=0", q); end
    rd(32'h08, q);
    total++; if (q !== 32'd1) begin bad++; $display("FAIL steplen_reset got=%h exp=1", q); end
  endtask

  task automatic test_halt_count();
    logic [31:0] q;
    wr(32'h00, 32'd1); m_state = 1;
    total++; if (halt !== 1'b1) begin bad++; $display("FAIL ctrl_halt got=%b exp=1", halt); end
    rd(32'h04, q);
    total++; if (q !== 32'd5) begin bad++; $display("FAIL status_halt got=%h exp=5", q); end
    // clear lands 2 clocks before the write task returns, the read samples 1 clock after it starts
    wr(32'h0C, $urandom);
    repeat (10) @(negedge clk);
    rd(32'h0C, q);
    total++; if (q !== 32'd13) begin bad++; $display("FAIL halt_count got=%0d exp=13", q); end
    wr(32'h0C, 32'd0);
    rd(32'h0C, q);
    total++; if (q !== 32'd3) begin bad++; $display("FAIL halt_count_clr got=%0d exp=3", q); end
    pulse(1'b0, 1'b1); m_state = 0;
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL run_pin got=%b exp=0", halt); end
    rd(32'h04, q);
    total++; if (q !== m_status()) begin bad++; $display("FAIL status_run got=%h exp=%h", q, m_status()); end
  endtask

  task automatic test_step();
    logic [31:0] q;
    logic [15:0] lens [4];
    int n;
    lens = '{16'd3, 16'd0, 16'($urandom_range(1, 8)), 16'($urandom_range(1, 8))};
    wr(32'h00, 32'd1); m_state = 1;
    foreach (lens[i]) begin
      wr(32'h08 | 32'($urandom_range(0, 3)), {16'($urandom), lens[i]}); m_len = lens[i];
      rd(32'h08, q);
      total++; if (q !== {16'd0, m_len}) begin bad++; $display("FAIL steplen_rd got=%h exp=%h", q, m_len); end
      pulse(1'b1, 1'b0);
      n = 0;
      while (halt === 1'b0 && n < 300) begin n++; @(negedge clk); end
      total++; if (n != ((m_len == 0) ? 1 : int'(m_len))) begin bad++; $display("FAIL step_len%0d got=%0d exp=%0d", i, n, (m_len == 0) ? 1 : int'(m_len)); end
      total++; if (halt !== 1'b1) begin bad++; $display("FAIL step_end got=%b exp=1", halt); end
    end
  endtask

  task automatic test_run_step();
    logic [31:0] q;
    pulse(1'b1, 1'b1); m_state = 0;
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL run_over_step got=%b exp=0", halt); end
    pulse(1'b1, 1'b0); m_state = 1;
    total++; if (halt !== 1'b1) begin bad++; $display("FAIL step_in_run got=%b exp=1", halt); end
    rd(32'h04, q);
    total++; if (q !== m_status()) begin bad++; $display("FAIL status_sir got=%h exp=%h", q, m_status()); end
  endtask

  task automatic test_step_abort();
    logic [31:0] q;
    wr(32'h08, 32'd100); m_len = 100;
    pulse(1'b1, 1'b0); m_state = 2;
    rd(32'h04, q);
    total++; if (q !== m_status()) begin bad++; $display("FAIL status_step got=%h exp=%h", q, m_status()); end
    wr(32'h00, 32'd1); m_state = 1;
    total++; if (halt !== 1'b1) begin bad++; $display("FAIL abort_halt got=%b exp=1", halt); end
    rd(32'h04, q);
    total++; if (q !== m_status()) begin bad++; $display("FAIL status_abort got=%h exp=%h", q, m_status()); end
  endtask

  task automatic test_regs();
    logic [31:0] q, d;
    int s;
    wr(32'h14, 32'hA5A5_5A5A); m_scr[0] = 32'hA5A5_5A5A;
    rd(32'h14, q);
    total++; if (q !== m_scr[0]) begin bad++; $display("FAIL scratch0_fixed got=%h exp=%h", q, m_scr[0]); end
    for (int k = 0; k < 8; k++) begin
      s = $urandom_range(0, 1); d = $urandom;
      wr(32'h14 + 32'(4 * s) + 32'($urandom_range(0, 3)), d); m_scr[s] = d;
      wr(32'h10, $urandom);
      wr(32'h04, $urandom);
      wr(32'h100 | (32'h14 + 32'(4 * s)), ~d);
      wr(32'h1C, $urandom);
      rd(32'h14, q);
      total++; if (q !== m_scr[0]) begin bad++; $display("FAIL scratch0_%0d got=%h exp=%h", k, q, m_scr[0]); end
      rd(32'h18, q);
      total++; if (q !== m_scr[1]) begin bad++; $display("FAIL scratch1_%0d got=%h exp=%h", k, q, m_scr[1]); end
    end
    rd(32'h10, q);
    total++; if (q !== ID) begin bad++; $display("FAIL id_after_wr got=%h exp=%h", q, ID); end
    rd(32'h114, q);
    total++; if (q !== 32'd0) begin bad++; $display("FAIL high_addr_rd got=%h exp=0", q); end
    rd(32'h04, q);
    total++; if (q !== m_status()) begin bad++; $display("FAIL status_regs got=%h exp=%h", q, m_status()); end
  endtask

  task automatic test_reset_mid_step();
    logic [31:0] q;
    wr(32'h18, $urandom | 32'd1);
    wr(32'h08, 32'd100);
    pulse(1'b1, 1'b0);
    rd(32'h04, q);
    #3 reset = 0;
    #1;
    m_state = 0; m_len = 16'd1; m_scr = '{32'd0, 32'd0};
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL async_halt got=%b exp=0", halt); end
    total++; if (data_in !== 32'd0) begin bad++; $display("FAIL async_data got=%h exp=0", data_in); end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    rd(32'h04, q);
    total++; if (q !== m_status()) begin bad++; $display("FAIL status_rst got=%h exp=%h", q, m_status()); end
    rd(32'h08, q);
    total++; if (q !== {16'd0, m_len}) begin bad++; $display("FAIL steplen_rst got=%h exp=%h", q, m_len); end
    rd(32'h14, q);
    total++; if (q !== m_scr[0]) begin bad++; $display("FAIL scratch0_rst got=%h exp=0", q); end
    rd(32'h18, q);
    total++; if (q !== m_scr[1]) begin bad++; $display("FAIL scratch1_rst got=%h exp=0", q); end
    rd(32'h0C, q);
    total++; if (q !== 32'd0) begin bad++; $display("FAIL hcount_rst got=%h exp=0", q); end
  endtask

  task automatic test_hold_enable();
    logic [31:0] q, prev;
    int changes;
    wr(32'h00, 32'd1); m_state = 1;
    rd(32'h10, q);
    rd_wr = 0; address = 32'h0C; enable = 1;
    prev = data_in; changes = 0;
    repeat (5) begin
      @(negedge clk);
      if (data_in !== prev) changes++;
      prev = data_in;
    end
    enable = 0;
    repeat (2) @(negedge clk);
    total++; if (changes != 1) begin bad++; $display("FAIL hold_enable got=%0d exp=1", changes); end
  endtask

  initial begin
    test_reset();
    test_halt_count();
    test_step();
    test_run_step();
    test_step_abort();
    test_regs();
    test_reset_mid_step();
    test_hold_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
